// File: rtl/grid_env_pkg.sv
// Shared definitions for the grid environment step block: action encoding,
// FSM states, default rewards and the registered step-result record.
package grid_env_pkg;

  localparam int unsigned ACTIONS_WIDTH = 2;

  typedef enum logic [ACTIONS_WIDTH-1:0] {
    ACT_RIGHT = 2'b00,
    ACT_UP    = 2'b01,
    ACT_LEFT  = 2'b10,
    ACT_DOWN  = 2'b11
  } action_e;

  typedef enum logic {
    IDLE,
    RESP
  } fsm_e;

  localparam int R_GOAL_DEF = 100;
  localparam int R_WALL_DEF = -10;
  localparam int R_STEP_DEF = -1;

  // Result fields use fixed maximum widths; the top slices them to its parameters.
  localparam int unsigned ST_W_MAX     = 32;
  localparam int unsigned REWARD_W_MAX = 64;

  typedef struct packed {
    logic [ST_W_MAX-1:0]            next_st;
    logic signed [REWARD_W_MAX-1:0] reward;
    logic                           re_random;
    logic                           done;
    logic                           timeout;
  } step_result_t;

  function automatic int unsigned state_idx(input int unsigned row,
                                            input int unsigned col,
                                            input int unsigned grid_w);
    return row * grid_w + col;
  endfunction

endpackage

// File: rtl/grid_env_step_if.sv
// Action/result handshake bundle between the action selector and the Q-table update path.
interface grid_env_step_if #(
  parameter int unsigned STATES_WIDTH = 5,
  parameter int unsigned REWARD_WIDTH = 16,
  parameter int unsigned STEP_WIDTH   = 7,
  parameter int unsigned EPI_WIDTH    = 16
);
  import grid_env_pkg::*;

  logic                           i_at_valid;
  logic                           o_at_ready;
  logic [ACTIONS_WIDTH-1:0]       i_at;
  logic [STATES_WIDTH-1:0]        o_st;
  logic                           o_res_valid;
  logic                           i_res_ready;
  logic [STATES_WIDTH-1:0]        o_next_st;
  logic signed [REWARD_WIDTH-1:0] o_reward;
  logic                           o_re_random;
  logic                           o_done;
  logic                           o_timeout;
  logic [STEP_WIDTH-1:0]          o_step_cnt;
  logic [EPI_WIDTH-1:0]           o_episode_cnt;

  modport master (
    output i_at_valid, i_at, i_res_ready,
    input  o_at_ready, o_st, o_res_valid, o_next_st, o_reward,
           o_re_random, o_done, o_timeout, o_step_cnt, o_episode_cnt
  );

  modport slave (
    input  i_at_valid, i_at, i_res_ready,
    output o_at_ready, o_st, o_res_valid, o_next_st, o_reward,
           o_re_random, o_done, o_timeout, o_step_cnt, o_episode_cnt
  );

endinterface

// File: rtl/grid_move_calc.sv
// Combinational move resolution on row/col: border and obstacle blocking,
// successor position and state index without divide or modulo.
module grid_move_calc
  import grid_env_pkg::*;
#(
  parameter int                         GRID_W        = 5,
  parameter int                         GRID_H        = 5,
  parameter logic [GRID_W*GRID_H-1:0]   OBSTACLE_MASK = '0
) (
  input  logic [$clog2(GRID_H)-1:0]        row,
  input  logic [$clog2(GRID_W)-1:0]        col,
  input  logic [$clog2(GRID_W*GRID_H)-1:0] st,
  input  logic [ACTIONS_WIDTH-1:0]         act,
  output logic [$clog2(GRID_H)-1:0]        next_row,
  output logic [$clog2(GRID_W)-1:0]        next_col,
  output logic [$clog2(GRID_W*GRID_H)-1:0] next_st,
  output logic                             blocked
);
  localparam int ROW_W = $clog2(GRID_H);
  localparam int COL_W = $clog2(GRID_W);
  localparam int ST_W  = $clog2(GRID_W*GRID_H);

  logic [ROW_W-1:0] cand_row;
  logic [COL_W-1:0] cand_col;
  logic [ST_W-1:0]  cand_st;
  logic             edge_hit;
  logic             obstacle_hit;

  always_comb begin
    cand_row = row;
    cand_col = col;
    cand_st  = st;
    edge_hit = 1'b0;
    case (action_e'(act))
      ACT_RIGHT:
        if (col == COL_W'(GRID_W - 1)) edge_hit = 1'b1;
        else begin
          cand_col = col + COL_W'(1);
          cand_st  = st + ST_W'(1);
        end
      ACT_UP:
        if (row == '0) edge_hit = 1'b1;
        else begin
          cand_row = row - ROW_W'(1);
          cand_st  = st - ST_W'(GRID_W);
        end
      ACT_LEFT:
        if (col == '0) edge_hit = 1'b1;
        else begin
          cand_col = col - COL_W'(1);
          cand_st  = st - ST_W'(1);
        end
      ACT_DOWN:
        if (row == ROW_W'(GRID_H - 1)) edge_hit = 1'b1;
        else begin
          cand_row = row + ROW_W'(1);
          cand_st  = st + ST_W'(GRID_W);
        end
    endcase
    // cand_st is only a valid cell index when the border check passed
    obstacle_hit = !edge_hit && OBSTACLE_MASK[cand_st];
    blocked      = edge_hit || obstacle_hit;
    next_row     = blocked ? row : cand_row;
    next_col     = blocked ? col : cand_col;
    next_st      = blocked ? st  : cand_st;
  end

endmodule

// File: rtl/grid_env_step.sv
// Registered grid-world step: one action per handshake, result held until consumed,
// with step/episode bookkeeping and restart handling.
module grid_env_step
  import grid_env_pkg::*;
#(
  parameter int                       GRID_W        = 5,
  parameter int                       GRID_H        = 5,
  parameter int                       START_ST      = 0,
  parameter int                       GOAL_ST       = GRID_W*GRID_H - 1,
  parameter logic [GRID_W*GRID_H-1:0] OBSTACLE_MASK = '0,
  parameter int                       MAX_STEPS     = 64,
  parameter int                       REWARD_WIDTH  = 16,
  parameter int                       R_GOAL        = R_GOAL_DEF,
  parameter int                       R_WALL        = R_WALL_DEF,
  parameter int                       R_STEP        = R_STEP_DEF,
  parameter int                       EPI_WIDTH     = 16
) (
  input logic            i_clk,
  input logic            i_rst,
  input logic            i_restart,
  grid_env_step_if.slave bus
);
  localparam int NUM_STATES   = GRID_W * GRID_H;
  localparam int STATES_WIDTH = $clog2(NUM_STATES);
  localparam int STEP_WIDTH   = $clog2(MAX_STEPS + 1);
  localparam int ROW_W        = $clog2(GRID_H);
  localparam int COL_W        = $clog2(GRID_W);
  localparam int START_ROW    = START_ST / GRID_W;
  localparam int START_COL    = START_ST % GRID_W;

  localparam step_result_t RES_RST = '{next_st: ST_W_MAX'(START_ST), reward: '0,
                                       re_random: 1'b0, done: 1'b0, timeout: 1'b0};

  if (OBSTACLE_MASK[START_ST] || OBSTACLE_MASK[GOAL_ST]) begin : g_mask_chk
    $error("grid_env_step: start or goal cell is marked as an obstacle");
  end
  if (STATES_WIDTH >= ST_W_MAX || REWARD_WIDTH >= REWARD_W_MAX) begin : g_width_chk
    $error("grid_env_step: state or reward width exceeds result record");
  end
  if (state_idx(START_ROW, START_COL, GRID_W) != START_ST) begin : g_start_chk
    $error("grid_env_step: start row/col inconsistent with START_ST");
  end

  fsm_e                    state_q, state_d;
  logic [STATES_WIDTH-1:0] st_q, mv_st;
  logic [ROW_W-1:0]        row_q, nrow_q, mv_row;
  logic [COL_W-1:0]        col_q, ncol_q, mv_col;
  logic                    mv_blocked;
  logic [STEP_WIDTH-1:0]   step_q, step_next;
  logic [EPI_WIDTH-1:0]    epi_q;
  step_result_t            res_q, res_d;
  logic                    restart_q, restart_seen;
  logic                    accept, commit, is_goal, is_timeout;
  logic                    unused_res_bits;

  grid_move_calc #(
    .GRID_W       (GRID_W),
    .GRID_H       (GRID_H),
    .OBSTACLE_MASK(OBSTACLE_MASK)
  ) u_move (
    .row     (row_q),
    .col     (col_q),
    .st      (st_q),
    .act     (bus.i_at),
    .next_row(mv_row),
    .next_col(mv_col),
    .next_st (mv_st),
    .blocked (mv_blocked)
  );

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    commit  = 1'b0;
    case (state_q)
      IDLE:
        if (bus.i_at_valid && !i_restart) begin
          accept  = 1'b1;
          state_d = RESP;
        end
      RESP:
        if (bus.i_res_ready) begin
          commit  = 1'b1;
          state_d = IDLE;
        end
    endcase
  end

  always_comb begin
    step_next  = step_q + STEP_WIDTH'(1);
    is_goal    = (mv_st == STATES_WIDTH'(GOAL_ST));
    is_timeout = (step_next == STEP_WIDTH'(MAX_STEPS)) && !is_goal;
    res_d.next_st   = ST_W_MAX'(mv_st);
    res_d.re_random = mv_blocked;
    res_d.done      = is_goal || is_timeout;
    res_d.timeout   = is_timeout;
    if (is_goal)         res_d.reward = REWARD_W_MAX'(R_GOAL);
    else if (mv_blocked) res_d.reward = REWARD_W_MAX'(R_WALL);
    else                 res_d.reward = REWARD_W_MAX'(R_STEP);
    restart_seen = restart_q || i_restart;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      st_q      <= STATES_WIDTH'(START_ST);
      row_q     <= ROW_W'(START_ROW);
      col_q     <= COL_W'(START_COL);
      nrow_q    <= ROW_W'(START_ROW);
      ncol_q    <= COL_W'(START_COL);
      step_q    <= '0;
      epi_q     <= '0;
      res_q     <= RES_RST;
      restart_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && i_restart) begin
        st_q   <= STATES_WIDTH'(START_ST);
        row_q  <= ROW_W'(START_ROW);
        col_q  <= COL_W'(START_COL);
        step_q <= '0;
      end
      if (accept) begin
        res_q  <= res_d;
        nrow_q <= mv_row;
        ncol_q <= mv_col;
      end
      // A restart seen while a result is pending is remembered until that result commits
      if (state_q == RESP && i_restart) restart_q <= 1'b1;
      if (commit) begin
        restart_q <= 1'b0;
        if (res_q.done || restart_seen) begin
          st_q   <= STATES_WIDTH'(START_ST);
          row_q  <= ROW_W'(START_ROW);
          col_q  <= COL_W'(START_COL);
          step_q <= '0;
          if (!restart_seen) epi_q <= epi_q + EPI_WIDTH'(1);
        end else begin
          st_q   <= res_q.next_st[STATES_WIDTH-1:0];
          row_q  <= nrow_q;
          col_q  <= ncol_q;
          step_q <= step_next;
        end
      end
    end
  end

  assign bus.o_at_ready    = (state_q == IDLE);
  assign bus.o_res_valid   = (state_q == RESP);
  assign bus.o_st          = st_q;
  assign bus.o_next_st     = res_q.next_st[STATES_WIDTH-1:0];
  assign bus.o_reward      = res_q.reward[REWARD_WIDTH-1:0];
  assign bus.o_re_random   = res_q.re_random;
  assign bus.o_done        = res_q.done;
  assign bus.o_timeout     = res_q.timeout;
  assign bus.o_step_cnt    = step_q;
  assign bus.o_episode_cnt = epi_q;

  assign unused_res_bits = ^{res_q.next_st[ST_W_MAX-1:STATES_WIDTH],
                             res_q.reward[REWARD_W_MAX-1:REWARD_WIDTH]};

endmodule

// File: tb/tb_grid_env_step.sv
// Bench for grid_env_step: a 5x5 instance with an obstacle at cell 6 and a
// 5x5 instance with MAX_STEPS=3, driven from a vector table plus corner sequences.
module tb_grid_env_step;
  import grid_env_pkg::*;

  typedef struct {
    int      which;
    action_e act;
    int      nst;
    int      rew;
    bit      rr;
    bit      done;
    bit      to;
  } vec_t;

  typedef struct {
    int nst;
    int rew;
    bit rr;
    bit done;
    bit to;
  } exp_t;

  typedef struct {
    int st, nst, rew, step, epi;
    bit at_rdy, rvalid, rr, done, to;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       at_valid_d [2];
  logic [1:0] at_d       [2];
  logic       res_ready_d[2];
  logic       restart_d  [2];

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];
  int   m_st[2], m_step[2], m_epi[2];
  obs_t obs[2];

  grid_env_step_if #(.STATES_WIDTH(5), .REWARD_WIDTH(16), .STEP_WIDTH(7), .EPI_WIDTH(16)) if_a ();
  grid_env_step_if #(.STATES_WIDTH(5), .REWARD_WIDTH(16), .STEP_WIDTH(2), .EPI_WIDTH(16)) if_b ();

  grid_env_step #(.GRID_W(5), .GRID_H(5), .OBSTACLE_MASK(25'h40), .MAX_STEPS(64)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_restart(restart_d[0]), .bus(if_a)
  );
  grid_env_step #(.GRID_W(5), .GRID_H(5), .MAX_STEPS(3)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_restart(restart_d[1]), .bus(if_b)
  );

  assign if_a.i_at_valid  = at_valid_d[0];
  assign if_a.i_at        = at_d[0];
  assign if_a.i_res_ready = res_ready_d[0];
  assign if_b.i_at_valid  = at_valid_d[1];
  assign if_b.i_at        = at_d[1];
  assign if_b.i_res_ready = res_ready_d[1];

  always_comb begin
    obs[0].st = int'(if_a.o_st);          obs[1].st = int'(if_b.o_st);
    obs[0].nst = int'(if_a.o_next_st);    obs[1].nst = int'(if_b.o_next_st);
    obs[0].rew = int'(if_a.o_reward);     obs[1].rew = int'(if_b.o_reward);
    obs[0].step = int'(if_a.o_step_cnt);  obs[1].step = int'(if_b.o_step_cnt);
    obs[0].epi = int'(if_a.o_episode_cnt); obs[1].epi = int'(if_b.o_episode_cnt);
    obs[0].at_rdy = if_a.o_at_ready;      obs[1].at_rdy = if_b.o_at_ready;
    obs[0].rvalid = if_a.o_res_valid;     obs[1].rvalid = if_b.o_res_valid;
    obs[0].rr = if_a.o_re_random;         obs[1].rr = if_b.o_re_random;
    obs[0].done = if_a.o_done;            obs[1].done = if_b.o_done;
    obs[0].to = if_a.o_timeout;           obs[1].to = if_b.o_timeout;
  end

  task automatic check(input string name, input int got, input int want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic check_result(input string tag, input int w, input exp_t e);
    check({tag, ".res_valid"}, int'(obs[w].rvalid), 1);
    check({tag, ".at_ready"},  int'(obs[w].at_rdy), 0);
    check({tag, ".next_st"},   obs[w].nst, e.nst);
    check({tag, ".reward"},    obs[w].rew, e.rew);
    check({tag, ".re_random"}, int'(obs[w].rr), int'(e.rr));
    check({tag, ".done"},      int'(obs[w].done), int'(e.done));
    check({tag, ".timeout"},   int'(obs[w].to), int'(e.to));
  endtask

  task automatic check_pos(input string tag, input int w);
    check({tag, ".st"},       obs[w].st,   m_st[w]);
    check({tag, ".step_cnt"}, obs[w].step, m_step[w]);
    check({tag, ".epi_cnt"},  obs[w].epi,  m_epi[w]);
  endtask

  task automatic launch(input string tag, input int w, input logic [1:0] a, input exp_t e);
    @(negedge clk);
    check({tag, ".ready_in"}, int'(obs[w].at_rdy), 1);
    at_valid_d[w] = 1'b1;
    at_d[w]       = a;
    sb.push_back(e);
    @(negedge clk);
    at_valid_d[w] = 1'b0;
  endtask

  task automatic collect(input string tag, input int w, output exp_t e);
    int k;
    k = 0;
    while (!obs[w].rvalid && k < 8) begin
      @(negedge clk);
      k++;
    end
    check({tag, ".latency"}, k, 0);
    if (sb.size() == 0) begin
      $display("FAIL %s.scoreboard: got empty queue, expected a pending result", tag);
      $fatal(1, "scoreboard underflow");
    end
    e = sb.pop_front();
    check_result(tag, w, e);
  endtask

  task automatic commit_res(input string tag, input int w, input exp_t e, input bit rs);
    res_ready_d[w] = 1'b1;
    @(negedge clk);
    res_ready_d[w] = 1'b0;
    if (e.done || rs) begin
      m_st[w]   = 0;
      m_step[w] = 0;
      if (!rs) m_epi[w]++;
    end else begin
      m_st[w] = e.nst;
      m_step[w]++;
    end
    check({tag, ".valid_after"}, int'(obs[w].rvalid), 0);
    check_pos({tag, ".commit"}, w);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[$];
    exp_t e;
    string tag;

    vecs.push_back('{0, ACT_RIGHT, 1,    -1, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{0, ACT_UP,    1,   -10, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{0, ACT_DOWN,  1,   -10, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{0, ACT_LEFT,  0,    -1, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{0, ACT_UP,    0,   -10, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{0, ACT_LEFT,  0,   -10, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{0, ACT_DOWN,  5,    -1, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{0, ACT_DOWN,  10,   -1, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{0, ACT_DOWN,  15,   -1, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{0, ACT_DOWN,  20,   -1, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{0, ACT_DOWN,  20,  -10, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{0, ACT_RIGHT, 21,   -1, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{0, ACT_RIGHT, 22,   -1, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{0, ACT_RIGHT, 23,   -1, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{0, ACT_RIGHT, 24,  100, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{0, ACT_RIGHT, 1,    -1, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{0, ACT_RIGHT, 2,    -1, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{0, ACT_RIGHT, 3,    -1, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{0, ACT_RIGHT, 4,    -1, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{0, ACT_RIGHT, 4,   -10, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{0, ACT_UP,    4,   -10, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1, ACT_UP,    0,   -10, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1, ACT_UP,    0,   -10, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1, ACT_UP,    0,   -10, 1'b1, 1'b1, 1'b1});

    for (int w = 0; w < 2; w++) begin
      at_valid_d[w] = 1'b0; at_d[w] = 2'b00; res_ready_d[w] = 1'b0; restart_d[w] = 1'b0;
      m_st[w] = state_idx(0, 0, 5); m_step[w] = 0; m_epi[w] = 0;
    end

    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int w = 0; w < 2; w++) begin
      tag = $sformatf("reset%0d", w);
      check({tag, ".at_ready"},  int'(obs[w].at_rdy), 1);
      check({tag, ".res_valid"}, int'(obs[w].rvalid), 0);
      check({tag, ".next_st"},   obs[w].nst, 0);
      check({tag, ".reward"},    obs[w].rew, 0);
      check({tag, ".re_random"}, int'(obs[w].rr), 0);
      check({tag, ".done"},      int'(obs[w].done), 0);
      check({tag, ".timeout"},   int'(obs[w].to), 0);
      check_pos(tag, w);
    end

    foreach (vecs[i]) begin
      tag = $sformatf("v%0d", i);
      e = '{vecs[i].nst, vecs[i].rew, vecs[i].rr, vecs[i].done, vecs[i].to};
      launch(tag, vecs[i].which, vecs[i].act, e);
      collect(tag, vecs[i].which, e);
      commit_res(tag, vecs[i].which, e, 1'b0);
    end

    // Restart in IDLE wins over a simultaneous action offer
    @(negedge clk);
    restart_d[0] = 1'b1; at_valid_d[0] = 1'b1; at_d[0] = ACT_DOWN;
    @(negedge clk);
    restart_d[0] = 1'b0; at_valid_d[0] = 1'b0;
    m_st[0] = 0; m_step[0] = 0;
    check("restart_idle.res_valid", int'(obs[0].rvalid), 0);
    check_pos("restart_idle", 0);

    // Restart while a result is pending: result unchanged, episode count kept
    launch("restart_resp", 0, ACT_RIGHT, '{1, -1, 1'b0, 1'b0, 1'b0});
    collect("restart_resp", 0, e);
    restart_d[0] = 1'b1;
    @(negedge clk);
    restart_d[0] = 1'b0;
    check_result("restart_resp.held", 0, e);
    commit_res("restart_resp", 0, e, 1'b1);

    // Result held while the consumer stalls, then discarded by reset
    launch("hold", 0, ACT_DOWN, '{5, -1, 1'b0, 1'b0, 1'b0});
    collect("hold", 0, e);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_result($sformatf("hold_c%0d", c), 0, e);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_st[0] = 0; m_step[0] = 0; m_epi[0] = 0;
    check("rst_resp.res_valid", int'(obs[0].rvalid), 0);
    check("rst_resp.at_ready",  int'(obs[0].at_rdy), 1);
    check("rst_resp.next_st",   obs[0].nst, 0);
    check("rst_resp.reward",    obs[0].rew, 0);
    check_pos("rst_resp", 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
